gsplat_tile_dispatcher: RTL and testbench

Frame-level initiator that drives the tile dispatch interface of gsplat_core. It walks a contiguous tile-descriptor list in DDR3, reading and validating each 2-qword header. It issues tile_start with the decoded parameters, then waits for tile_done. While the core rasterizes, it prefetches the next header into a single-entry buffer.

---
 rtl/gsplat_tile_dispatcher_if.sv | 33 +++
 rtl/gsplat_tile_dispatcher.sv | 217 +++++++++++++++++++++
 tb/tb_gsplat_tile_dispatcher.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gsplat_tile_dispatcher_if.sv
// Tile dispatcher bus bundle: DDR3 header read port plus tile dispatch port toward gsplat_core.
// master = dispatcher side, slave = memory/core side.
interface gsplat_tile_dispatcher_if;
    logic [28:0] rd_addr;
    logic [7:0]  rd_burstcnt;
    logic        rd_req;
    logic        rd_ack;
    logic [63:0] rd_data;
    logic        rd_data_valid;

    logic        tile_start;
    logic [28:0] tile_addr;
    logic [15:0] tile_px;
    logic [15:0] tile_py;
    logic [31:0] tile_splat_count;
    logic [28:0] fb_base;
    logic        tile_done;
    logic        core_busy;

    modport master (
        output rd_addr, rd_burstcnt, rd_req,
        input  rd_ack, rd_data, rd_data_valid,
        output tile_start, tile_addr, tile_px, tile_py, tile_splat_count, fb_base,
        input  tile_done, core_busy
    );

    modport slave (
        input  rd_addr, rd_burstcnt, rd_req,
        output rd_ack, rd_data, rd_data_valid,
        input  tile_start, tile_addr, tile_px, tile_py, tile_splat_count, fb_base,
        output tile_done, core_busy
    );
endinterface

// File: rtl/gsplat_tile_dispatcher.sv
// Frame-level initiator for gsplat_core: walks the DDR3 tile-descriptor list, validates each
// 2-qword header, dispatches one tile at a time and prefetches the next header meanwhile.
module gsplat_tile_dispatcher #(
    parameter logic [31:0] HDR_MAGIC  = 32'h54494C45,
    parameter logic [31:0] MAX_SPLATS = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [28:0] list_base,
    input  logic [15:0] tile_count,
    input  logic [28:0] fb_base_in,
    output logic        busy,
    output logic        frame_done,
    output logic        error,
    gsplat_tile_dispatcher_if.master bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]  state_q, state_d;

    logic [28:0] fetch_addr_q;
    logic [28:0] fb_base_q;
    logic [15:0] count_q;
    logic [15:0] fetched_q;
    logic [15:0] dispatched_q;
    logic [15:0] completed_q;
    logic        outstanding_q;
    logic        error_q;
    logic        busy_q;
    logic        frame_done_q;

    // Read channel: rd_req_q while waiting for ack, in_flight_q while collecting the two beats.
    logic        rd_req_q;
    logic [28:0] rd_addr_q;
    logic        in_flight_q;
    logic        beat_q;
    logic [63:0] qword0_q;

    // Single-entry prefetched header buffer.
    logic        buf_valid_q;
    logic [28:0] buf_addr_q;
    logic [15:0] buf_px_q;
    logic [15:0] buf_py_q;
    logic [31:0] buf_cnt_q;

    logic        tile_start_q;
    logic [28:0] tile_addr_q;
    logic [15:0] tile_px_q;
    logic [15:0] tile_py_q;
    logic [31:0] tile_cnt_q;

    logic        accept;
    logic        in_run;
    logic        fetch_issue;
    logic        ack_take;
    logic        beat0;
    logic        beat1;
    logic [31:0] hdr_cnt;
    logic        hdr_bad;
    logic        hdr_err;
    logic [28:0] next_addr;
    logic        dispatch;
    logic        retire;
    logic        all_done;

    always_comb begin
        accept      = (state_q == StIdle) && frame_start;
        in_run      = (state_q == StRun);
        fetch_issue = in_run && !buf_valid_q && (fetched_q < count_q) && !rd_req_q && !in_flight_q;
        ack_take    = rd_req_q && bus.rd_ack;
        beat0       = in_flight_q && bus.rd_data_valid && !beat_q;
        beat1       = in_flight_q && bus.rd_data_valid && beat_q;
        hdr_cnt     = qword0_q[63:32];
        hdr_bad     = (bus.rd_data[31:0] != HDR_MAGIC) || (hdr_cnt > MAX_SPLATS);
        hdr_err     = beat1 && hdr_bad;
        // Descriptor stride is the 2-qword header plus 4 qwords per splat; wraps at 2^29.
        next_addr   = fetch_addr_q + 29'd2 + {hdr_cnt[26:0], 2'b00};
        // Requiring outstanding clear keeps exactly one tile in flight, even across tile_done.
        dispatch    = in_run && buf_valid_q && !outstanding_q && !bus.core_busy;
        retire      = outstanding_q && bus.tile_done;
        all_done    = (completed_q == count_q) && (dispatched_q == count_q) && !outstanding_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (frame_start) state_d = StRun;
            end
            StRun: begin
                if (hdr_err)       state_d = StDrain;
                else if (all_done) state_d = StDone;
            end
            StDrain: begin
                if (!outstanding_q) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            fetch_addr_q  <= '0;
            fb_base_q     <= '0;
            count_q       <= '0;
            fetched_q     <= '0;
            dispatched_q  <= '0;
            completed_q   <= '0;
            outstanding_q <= 1'b0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            in_flight_q   <= 1'b0;
            beat_q        <= 1'b0;
            qword0_q      <= '0;
            buf_valid_q   <= 1'b0;
            buf_addr_q    <= '0;
            buf_px_q      <= '0;
            buf_py_q      <= '0;
            buf_cnt_q     <= '0;
            tile_start_q  <= 1'b0;
            tile_addr_q   <= '0;
            tile_px_q     <= '0;
            tile_py_q     <= '0;
            tile_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= (state_q == StDone);
            tile_start_q <= dispatch;

            if (accept) begin
                fetch_addr_q  <= list_base;
                fb_base_q     <= fb_base_in;
                count_q       <= tile_count;
                fetched_q     <= '0;
                dispatched_q  <= '0;
                completed_q   <= '0;
                outstanding_q <= 1'b0;
                error_q       <= 1'b0;
                busy_q        <= 1'b1;
                buf_valid_q   <= 1'b0;
                rd_req_q      <= 1'b0;
                in_flight_q   <= 1'b0;
                beat_q        <= 1'b0;
            end else begin
                if (state_q == StDone) busy_q <= 1'b0;

                if (fetch_issue) begin
                    rd_req_q  <= 1'b1;
                    rd_addr_q <= fetch_addr_q;
                end else if (ack_take) begin
                    rd_req_q    <= 1'b0;
                    in_flight_q <= 1'b1;
                    beat_q      <= 1'b0;
                end

                if (beat0) begin
                    qword0_q <= bus.rd_data;
                    beat_q   <= 1'b1;
                end

                if (beat1) begin
                    in_flight_q <= 1'b0;
                    beat_q      <= 1'b0;
                    if (hdr_bad) begin
                        error_q <= 1'b1;
                    end else begin
                        buf_valid_q  <= 1'b1;
                        buf_addr_q   <= fetch_addr_q;
                        buf_px_q     <= qword0_q[15:0];
                        buf_py_q     <= qword0_q[31:16];
                        buf_cnt_q    <= hdr_cnt;
                        fetch_addr_q <= next_addr;
                        fetched_q    <= fetched_q + 16'd1;
                    end
                end

                if (dispatch) begin
                    buf_valid_q   <= 1'b0;
                    outstanding_q <= 1'b1;
                    dispatched_q  <= dispatched_q + 16'd1;
                    tile_addr_q   <= buf_addr_q;
                    tile_px_q     <= buf_px_q;
                    tile_py_q     <= buf_py_q;
                    tile_cnt_q    <= buf_cnt_q;
                end else if (retire) begin
                    outstanding_q <= 1'b0;
                    completed_q   <= completed_q + 16'd1;
                end
            end
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign error      = error_q;

    assign bus.rd_addr          = rd_addr_q;
    assign bus.rd_burstcnt      = rd_req_q ? 8'd2 : 8'd0;
    assign bus.rd_req           = rd_req_q;
    assign bus.tile_start       = tile_start_q;
    assign bus.tile_addr        = tile_addr_q;
    assign bus.tile_px          = tile_px_q;
    assign bus.tile_py          = tile_py_q;
    assign bus.tile_splat_count = tile_cnt_q;
    assign bus.fb_base          = fb_base_q;

endmodule

// File: tb/tb_gsplat_tile_dispatcher.sv
// Directed bench for gsplat_tile_dispatcher with a DDR3 header responder and a core model.
module tb_gsplat_tile_dispatcher;

    localparam logic [31:0] MAGIC = 32'h54494C45;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start;
    logic [28:0] list_base;
    logic [15:0] tile_count;
    logic [28:0] fb_base_in;
    logic        busy;
    logic        frame_done;
    logic        error;

    gsplat_tile_dispatcher_if bus ();

    gsplat_tile_dispatcher dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .list_base  (list_base),
        .tile_count (tile_count),
        .fb_base_in (fb_base_in),
        .busy       (busy),
        .frame_done (frame_done),
        .error      (error),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [63:0] mem [int unsigned];
    int          ack_delay = 0;
    logic        stray_req = 1'b0;
    logic [28:0] resp_addr;
    logic [28:0] addr_log[$];
    logic        busy_at_fetch[$];

    // Header memory responder: ack after ack_delay cycles, then qword0 and qword1 back to back.
    initial begin
        bus.rd_ack        = 1'b0;
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        forever begin
            @(negedge clk);
            bus.rd_ack        = 1'b0;
            bus.rd_data_valid = stray_req;
            bus.rd_data       = 64'hFFFF_FFFF_FFFF_FFFF;
            if (reset_n && bus.rd_req) begin
                resp_addr = bus.rd_addr;
                check_eq("burstcnt", bus.rd_burstcnt, 64'd2);
                addr_log.push_back(resp_addr);
                busy_at_fetch.push_back(bus.core_busy);
                for (int i = 0; i < ack_delay && reset_n; i++) begin
                    @(negedge clk);
                    if (reset_n) begin
                        check_eq("req_hold", bus.rd_req, 64'd1);
                        check_eq("addr_hold", bus.rd_addr, resp_addr);
                    end
                end
                if (reset_n) begin
                    bus.rd_ack = 1'b1;
                    @(negedge clk);
                    bus.rd_ack = 1'b0;
                    check_eq("req_drop", bus.rd_req, 64'd0);
                    bus.rd_data_valid = 1'b1;
                    bus.rd_data       = mem[resp_addr];
                    @(negedge clk);
                    bus.rd_data = mem[resp_addr + 29'd1];
                    @(negedge clk);
                    bus.rd_data_valid = 1'b0;
                end
            end
        end
    end

    int          core_lat = 8;
    logic [15:0] st_px[$];
    logic [15:0] st_py[$];
    logic [31:0] st_cnt[$];
    logic [28:0] st_addr[$];
    int          st_edge[$];
    int          done_edge[$];

    // Core model: busy for core_lat cycles per tile, tile_done drops together with core_busy.
    initial begin
        bus.tile_done = 1'b0;
        bus.core_busy = 1'b0;
        forever begin
            @(negedge clk);
            bus.tile_done = 1'b0;
            if (!reset_n) begin
                bus.core_busy = 1'b0;
            end else if (bus.tile_start) begin
                st_px.push_back(bus.tile_px);
                st_py.push_back(bus.tile_py);
                st_cnt.push_back(bus.tile_splat_count);
                st_addr.push_back(bus.tile_addr);
                st_edge.push_back(cyc);
                bus.core_busy = 1'b1;
                for (int i = 0; i < core_lat && reset_n; i++) begin
                    @(negedge clk);
                    check_eq("start_while_busy", bus.tile_start, 64'd0);
                end
                bus.core_busy = 1'b0;
                bus.tile_done = reset_n;
                if (reset_n) done_edge.push_back(cyc + 1);
            end
        end
    end

    int a0, s0, d0;

    task automatic mark_logs();
        a0 = addr_log.size();
        s0 = st_px.size();
        d0 = done_edge.size();
    endtask

    task automatic start_frame(input logic [28:0] base, input logic [15:0] cnt,
                               input logic [28:0] fb, output int f_edge);
        @(negedge clk);
        list_base   = base;
        tile_count  = cnt;
        fb_base_in  = fb;
        frame_start = 1'b1;
        f_edge      = cyc + 1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_frame_done(input int limit, output int fd_edge);
        int n;
        n = 0;
        while (!frame_done && n < limit) begin
            @(negedge clk);
            n++;
        end
        fd_edge = cyc;
        check_eq("frame_done_seen", frame_done, 64'd1);
    endtask

    int f_edge, fd_edge;

    initial begin
        frame_start = 1'b0;
        list_base   = '0;
        tile_count  = '0;
        fb_base_in  = '0;

        #1;
        check_eq("rst_busy", busy, 64'd0);
        check_eq("rst_frame_done", frame_done, 64'd0);
        check_eq("rst_error", error, 64'd0);
        check_eq("rst_rd_req", bus.rd_req, 64'd0);
        check_eq("rst_tile_start", bus.tile_start, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Empty frame
        mark_logs();
        start_frame(29'h100, 16'd0, 29'h0AA, f_edge);
        check_eq("zero_busy", busy, 64'd1);
        wait_frame_done(20, fd_edge);
        check_eq("zero_done_lat", fd_edge - f_edge, 64'd2);
        check_eq("zero_busy_end", busy, 64'd0);
        @(negedge clk);
        check_eq("zero_done_pulse", frame_done, 64'd0);
        check_eq("zero_no_req", addr_log.size() - a0, 64'd0);
        check_eq("zero_no_start", st_px.size() - s0, 64'd0);

        // Single tile
        mem[32'h100] = {32'd3, 16'd32, 16'd64};
        mem[32'h101] = {32'h0, MAGIC};
        mark_logs();
        start_frame(29'h100, 16'd1, 29'h1234, f_edge);
        wait_frame_done(200, fd_edge);
        check_eq("one_nreq", addr_log.size() - a0, 64'd1);
        check_eq("one_rd_addr", addr_log[a0], 64'h100);
        check_eq("one_nstart", st_px.size() - s0, 64'd1);
        check_eq("one_px", st_px[s0], 64'd64);
        check_eq("one_py", st_py[s0], 64'd32);
        check_eq("one_cnt", st_cnt[s0], 64'd3);
        check_eq("one_addr", st_addr[s0], 64'h100);
        check_eq("one_lat_ge4", (st_edge[s0] - f_edge) >= 4, 64'd1);
        check_eq("one_done_after_tile", fd_edge > done_edge[d0], 64'd1);
        check_eq("one_fb_base", bus.fb_base, 64'h1234);
        check_eq("one_error", error, 64'd0);

        // Three tiles: 0x100 -> 0x106 -> 0x108
        mem[32'h100] = {32'd1, 16'd2, 16'd1};
        mem[32'h101] = {32'h0, MAGIC};
        mem[32'h106] = {32'd0, 16'd4, 16'd3};
        mem[32'h107] = {32'hABCD, MAGIC};
        mem[32'h108] = {32'd5, 16'd6, 16'd5};
        mem[32'h109] = {32'h0, MAGIC};
        mark_logs();
        start_frame(29'h100, 16'd3, 29'h0, f_edge);
        wait_frame_done(400, fd_edge);
        check_eq("three_nreq", addr_log.size() - a0, 64'd3);
        check_eq("three_addr0", addr_log[a0], 64'h100);
        check_eq("three_addr1", addr_log[a0 + 1], 64'h106);
        check_eq("three_addr2", addr_log[a0 + 2], 64'h108);
        check_eq("three_prefetch_busy", busy_at_fetch[a0 + 1], 64'd1);
        check_eq("three_nstart", st_px.size() - s0, 64'd3);
        check_eq("three_ndone", done_edge.size() - d0, 64'd3);
        check_eq("three_px1", st_px[s0 + 1], 64'd3);
        check_eq("three_cnt2", st_cnt[s0 + 2], 64'd5);
        check_eq("three_addr_t2", st_addr[s0 + 2], 64'h108);
        check_eq("three_gap1", st_edge[s0 + 1] - done_edge[d0], 64'd1);
        check_eq("three_gap2", st_edge[s0 + 2] - done_edge[d0 + 1], 64'd1);

        // Delayed ack plus a frame_start that must be ignored mid-frame
        mem[32'h100] = {32'd3, 16'd32, 16'd64};
        mem[32'h101] = {32'h0, MAGIC};
        ack_delay = 7;
        mark_logs();
        start_frame(29'h100, 16'd1, 29'h0, f_edge);
        repeat (2) @(negedge clk);
        list_base   = 29'h999;
        tile_count  = 16'd0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_frame_done(300, fd_edge);
        ack_delay = 0;
        check_eq("dly_nreq", addr_log.size() - a0, 64'd1);
        check_eq("dly_nstart", st_px.size() - s0, 64'd1);
        check_eq("dly_addr", st_addr[s0], 64'h100);

        // Bad magic on the second header while tile 0 runs
        mem[32'h200] = {32'd2, 16'h11, 16'h22};
        mem[32'h201] = {32'h0, MAGIC};
        mem[32'h20A] = {32'd1, 16'd2, 16'd3};
        mem[32'h20B] = {32'h0, 32'hDEAD_BEEF};
        mark_logs();
        start_frame(29'h200, 16'd2, 29'h0, f_edge);
        wait_frame_done(300, fd_edge);
        check_eq("bad_addr1", addr_log[a0 + 1], 64'h20A);
        check_eq("bad_nstart", st_px.size() - s0, 64'd1);
        check_eq("bad_done_after_tile", fd_edge > done_edge[d0], 64'd1);
        check_eq("bad_error", error, 64'd1);
        repeat (4) @(negedge clk);
        check_eq("bad_error_sticky", error, 64'd1);
        check_eq("bad_busy", busy, 64'd0);

        // splat_count == MAX_SPLATS is legal, MAX_SPLATS+1 is not
        mem[32'h300]    = {32'h0010_0000, 16'd7, 16'd8};
        mem[32'h301]    = {32'h0, MAGIC};
        mem[32'h400302] = {32'h0010_0001, 16'd9, 16'd9};
        mem[32'h400303] = {32'h0, MAGIC};
        mark_logs();
        start_frame(29'h300, 16'd2, 29'h0, f_edge);
        check_eq("max_error_cleared", error, 64'd0);
        wait_frame_done(300, fd_edge);
        check_eq("max_addr1", addr_log[a0 + 1], 64'h400302);
        check_eq("max_nstart", st_px.size() - s0, 64'd1);
        check_eq("max_cnt", st_cnt[s0], 64'h0010_0000);
        check_eq("max_error", error, 64'd1);

        // Asynchronous reset in the middle of a fetch
        ack_delay = 30;
        start_frame(29'h100, 16'd1, 29'h55, f_edge);
        for (int i = 0; i < 10 && !bus.rd_req; i++) @(negedge clk);
        check_eq("rst_req_seen", bus.rd_req, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 64'd0);
        check_eq("arst_rd_req", bus.rd_req, 64'd0);
        check_eq("arst_rd_addr", bus.rd_addr, 64'd0);
        check_eq("arst_burstcnt", bus.rd_burstcnt, 64'd0);
        check_eq("arst_error", error, 64'd0);
        check_eq("arst_fb_base", bus.fb_base, 64'd0);
        check_eq("arst_tile_addr", bus.tile_addr, 64'd0);
        check_eq("arst_tile_px", bus.tile_px, 64'd0);
        check_eq("arst_tile_cnt", bus.tile_splat_count, 64'd0);
        repeat (2) @(negedge clk);
        ack_delay = 0;
        reset_n   = 1'b1;
        stray_req = 1'b1;
        repeat (3) @(negedge clk);
        stray_req = 1'b0;
        @(negedge clk);
        check_eq("stray_busy", busy, 64'd0);
        check_eq("stray_rd_req", bus.rd_req, 64'd0);
        check_eq("stray_error", error, 64'd0);
        mark_logs();
        start_frame(29'h100, 16'd1, 29'h77, f_edge);
        wait_frame_done(200, fd_edge);
        check_eq("post_nstart", st_px.size() - s0, 64'd1);
        check_eq("post_px", st_px[s0], 64'd64);
        check_eq("post_cnt", st_cnt[s0], 64'd3);
        check_eq("post_fb_base", bus.fb_base, 64'h77);
        check_eq("post_error", error, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
